// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, WIDTH cycles per operation.
// Optional subtract mode (a-b via ~b and carry-in 1) is enabled with `define SERIAL_ADDER_SUB_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | processing one bit per clock
//   DONE   | one-cycle result pulse, may accept a new start
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_psum;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_carry_nx;
    logic [WIDTH:0]   w_psum_ext;
    logic [WIDTH-1:0] w_psum_nx;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load   = i_sub ? ~i_b : i_b;
    assign w_cin_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load   = i_b;
    assign w_cin_load = i_cin;
`endif

    assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_nx = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    // Widened shift keeps the sum-bit insertion legal for WIDTH=1.
    assign w_psum_ext = {w_sum, r_psum} >> 1;
    assign w_psum_nx  = w_psum_ext[WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_b_load;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_psum  <= w_psum_nx;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_nx;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        // r_carry here is the carry into the MSB.
                        r_s     <= w_psum_nx;
                        r_cout  <= w_carry_nx;
                        r_ovf   <= r_carry ^ w_carry_nx;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);
    assign o_s    = r_s;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder built around a single full-adder cell and a carry flip-flop. It adds two WIDTH-bit operands plus a carry-in LSB-first, one bit per clock, over WIDTH cycles. A start/busy/done handshake frames each operation. The block is the area-minimal arithmetic option for datapaths that can tolerate WIDTH-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only when not busy.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- Cin  input  1  carry-in; captured on an accepted start.
- sub  input  1  subtract-mode select; the port exists only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  WIDTH  sum register.
- Cout  output  1  final carry-out.
- ovf  output  1  two's-complement overflow, equal to carry into the MSB XOR carry out of the MSB.

## Operation
States:
- IDLE: waiting for start.
- RUN: processing bits.
- DONE: one-cycle result pulse.

Transitions and per-state behaviour:
- IDLE or DONE with start=1: load shift registers A<=a, B<=b and carry<=Cin; clear the bit counter; go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - Apply the full-adder equations to A[0], B[0] and carry: sum bit = A[0]^B[0]^carry; next carry = (A[0]&B[0]) | (carry&(A[0]^B[0])).
  - Shift the sum bit into the MSB of the partial-sum register.
  - Shift A and B right by one.
  - Increment the counter.
- RUN, on the cycle processing bit WIDTH-1:
  - Copy the completed partial sum into s.
  - Cout <= final carry.
  - ovf <= carry-in to bit WIDTH-1 XOR final carry.
  - Go to DONE.

Output rules:
- busy = (state==RUN).
- done = (state==DONE).
- s, Cout and ovf change only at completion. They hold their last result through later operations until the next completion.
- start while in RUN is ignored. No queueing; the operands are not re-sampled.
- a, b and Cin may change freely after the accepting edge.
- WIDTH=1: a single RUN cycle; ovf = Cin XOR Cout.
- Counter width is $clog2(WIDTH+1). It must not wrap before reaching WIDTH-1.

## Timing
- Start accepted at edge k: busy=1 after edge k. Bit i is processed at edge k+1+i.
- After edge k+WIDTH: busy=0, done=1, and s, Cout and ovf are valid.
- After edge k+WIDTH+1: done=0, unless a start accepted during DONE has begun a new operation. In that case busy=1 and done=0.
- Throughput: one operation per WIDTH+1 cycles back-to-back.
- Reset, at any edge where rst=1, including mid-RUN:
  - state=IDLE, busy=0, done=0, s=0, Cout=0, ovf=0.
  - Shift registers, carry and counter cleared.
  - rst has priority over start.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - An accepted start with sub=1 loads B<=~b and carry<=1; Cin is ignored.
  - The result is a-b. Cout=1 means no borrow, and ovf is the signed-subtract overflow.
  - With sub=0, behaviour is identical to the base add.
- SERIAL_ADDER_SUB_EN not defined: no sub port; the block always adds.

## Test plan
All scenarios use WIDTH=8.
- Reset, then a=0x5A, b=0x3C, Cin=0, start pulse -> busy for 8 cycles; done pulse 8 cycles after the accepting edge; s=0x96, Cout=0, ovf=1.
- a=0xFF, b=0x01, Cin=0 -> s=0x00, Cout=1, ovf=0. Then a=0x7F, b=0x00, Cin=1 -> s=0x80, Cout=0, ovf=1.
- Start held high continuously with a=0x01, b=0x01 -> exactly one operation per 9 cycles. Operand changes while busy do not affect the result: s=0x02 each time.
- rst asserted 3 cycles into RUN -> next cycle busy=0, done=0, s=0x00, Cout=0, ovf=0. A following start completes normally.
- Start asserted during RUN -> ignored; the done pulse timing is unchanged and s is the first operation's result.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> s=0x0F, Cout=1, ovf=0. Then a=0x00, b=0x01 -> s=0xFF, Cout=0. Then a=0x80, b=0x01 -> s=0x7F, ovf=1.
